// File: rtl/logic_pipe_unit_if.sv
// Handshake bus of the logic pipe unit: the input operands with their
// valid/ready pair, the result outputs with theirs, and the transaction
// counter with its clear.
interface logic_pipe_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   localparam int ONES_W = $clog2(WIDTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [WIDTH-1:0]  c;
   logic [1:0]        op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  x;
   logic [WIDTH-1:0]  y;
   logic [ONES_W-1:0] x_ones;
   logic              clr_count;
   logic [CNT_W-1:0]  txn_count;

   // The source/sink side: drives operands, output backpressure and the clear
   modport master (
      output in_valid, a, b, c, op, out_ready, clr_count,
      input  in_ready, out_valid, x, y, x_ones, txn_count
   );

   // The unit side
   modport slave (
      input  in_valid, a, b, c, op, out_ready, clr_count,
      output in_ready, out_valid, x, y, x_ones, txn_count
   );
endinterface

// File: rtl/logic_pipe_unit.sv
// Two-stage pipelined bitwise logic/arithmetic evaluator over operands
// a, b, c. Stage 1 holds the selected function results x/y, stage 2 holds
// x, y and the popcount of x and drives the outputs. Both stages stall
// independently so up to two items are buffered under backpressure, and a
// saturating counter tracks completed output handshakes.
module logic_pipe_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   logic_pipe_unit_if.slave bus
);
   localparam int ONES_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              w_adv1;
   logic              w_adv2;
   logic              w_outFire;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_fnX;
   logic [WIDTH-1:0]  w_fnY;
   logic [ONES_W-1:0] w_s1Ones;

   logic              r_s1Valid;
   logic [WIDTH-1:0]  r_s1X;
   logic [WIDTH-1:0]  r_s1Y;
   logic              r_s2Valid;
   logic [WIDTH-1:0]  r_s2X;
   logic [WIDTH-1:0]  r_s2Y;
   logic [ONES_W-1:0] r_s2Ones;
   logic [CNT_W-1:0]  r_txnCount;

   // A stage may load when it is empty or its contents move on this cycle;
   // out_ready -> in_ready is the only combinational path through the unit.
   assign w_adv2    = ~r_s2Valid | bus.out_ready;
   assign w_adv1    = ~r_s1Valid | w_adv2;
   assign w_outFire = r_s2Valid & bus.out_ready;

   // Carry-in is only the low bit of c; the upper c bits play no part in op 3
   assign w_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c[0]};

   // Function select on the incoming operands
   always_comb begin
      w_fnX = '0;
      w_fnY = '0;
      case (bus.op)
         2'd0: begin
            w_fnX = ~bus.c ^ (bus.a | bus.b);
            w_fnY = bus.a & bus.b;
         end
         2'd1: begin
            w_fnX = bus.a ^ bus.b ^ bus.c;
            w_fnY = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
         end
         2'd2: begin
            w_fnX = (bus.a & ~bus.c) | (bus.b & bus.c);
            w_fnY = bus.a | bus.b;
         end
         default: begin
            w_fnX = w_sum[WIDTH-1:0];
            w_fnY = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
         end
      endcase
   end

   // Popcount of the stage-1 x, captured alongside it into stage 2
   always_comb begin
      w_s1Ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_s1Ones = w_s1Ones + ONES_W'(r_s1X[i]);
      end
   end

   // Stage 1: capture function results when an input is accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1X     <= '0;
         r_s1Y     <= '0;
      end else if (w_adv1) begin
         r_s1Valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1X <= w_fnX;
            r_s1Y <= w_fnY;
         end
      end
   end

   // Stage 2: output register, holds steady while the sink stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_s2X     <= '0;
         r_s2Y     <= '0;
         r_s2Ones  <= '0;
      end else if (w_adv2) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2X    <= r_s1X;
            r_s2Y    <= r_s1Y;
            r_s2Ones <= w_s1Ones;
         end
      end
   end

   // Completed-handshake counter; clear takes priority, then saturate
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_txnCount <= '0;
      end else if (bus.clr_count) begin
         r_txnCount <= '0;
      end else if (w_outFire && (r_txnCount != CNT_MAX)) begin
         r_txnCount <= r_txnCount + 1'b1;
      end
   end

   assign bus.in_ready  = w_adv1;
   assign bus.out_valid = r_s2Valid;
   assign bus.x         = r_s2X;
   assign bus.y         = r_s2Y;
   assign bus.x_ones    = r_s2Ones;
   assign bus.txn_count = r_txnCount;
endmodule

// File: tb/tb_logic_pipe_unit.sv
// Testbench for logic_pipe_unit: table of operand/result vectors streamed
// through a scoreboard, plus hand-written stall, counter and reset sequences.
// A second instance with a 4-bit counter exercises saturation and clear.
module tb_logic_pipe_unit;
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [3:0] ones;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      exp_t       e;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   expTxn;
   int   hs2;
   exp_t sb[$];
   vec_t vecs[0:10];

   logic_pipe_unit_if #(.WIDTH(8), .CNT_W(16)) bus ();
   logic_pipe_unit_if #(.WIDTH(8), .CNT_W(4))  bus2 ();

   logic_pipe_unit #(.WIDTH(8), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic_pipe_unit #(.WIDTH(8), .CNT_W(4)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and log a failure
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one item to the main unit; push its expected result once accepted
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c, input exp_t e);
      bit accepted;
      accepted     = 1'b0;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.c        = c;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 50 && !accepted; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(e);
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1");
      end
      bus.in_valid = 1'b0;
   endtask

   // Output monitor: every output handshake is matched against the scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got x=%0h expected no output", bus.x);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("out_x", 32'(bus.x), 32'(e.x));
            checkOutput("out_y", 32'(bus.y), 32'(e.y));
            checkOutput("out_x_ones", 32'(bus.x_ones), 32'(e.ones));
         end
         expTxn++;
      end
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      checks = 0;
      errors = 0;
      expTxn = 0;
      hs2    = 0;

      vecs[0]  = '{2'd0, 8'h0F, 8'h33, 8'h55, '{8'h95, 8'h03, 4'd4}};
      vecs[1]  = '{2'd3, 8'hFF, 8'h01, 8'h01, '{8'h01, 8'h01, 4'd1}};
      vecs[2]  = '{2'd3, 8'h10, 8'h20, 8'h00, '{8'h30, 8'h00, 4'd2}};
      vecs[3]  = '{2'd1, 8'hF0, 8'hCC, 8'hAA, '{8'h96, 8'hE8, 4'd4}};
      vecs[4]  = '{2'd2, 8'hF0, 8'hCC, 8'hAA, '{8'hD8, 8'hFC, 4'd4}};
      vecs[5]  = '{2'd0, 8'h00, 8'h00, 8'h00, '{8'hFF, 8'h00, 4'd8}};
      vecs[6]  = '{2'd1, 8'hFF, 8'hFF, 8'hFF, '{8'hFF, 8'hFF, 4'd8}};
      vecs[7]  = '{2'd2, 8'hAA, 8'h55, 8'h0F, '{8'hA5, 8'hFF, 4'd4}};
      vecs[8]  = '{2'd3, 8'h80, 8'h80, 8'hFF, '{8'h01, 8'h01, 4'd1}};
      vecs[9]  = '{2'd3, 8'h7F, 8'h00, 8'h01, '{8'h80, 8'h00, 4'd1}};
      vecs[10] = '{2'd2, 8'h00, 8'hFF, 8'h00, '{8'h00, 8'hFF, 4'd0}};

      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.c          = '0;
      bus.op         = '0;
      bus.out_ready  = 1'b1;
      bus.clr_count  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.a         = 8'h12;
      bus2.b         = 8'h34;
      bus2.c         = 8'h56;
      bus2.op        = 2'd1;
      bus2.out_ready = 1'b1;
      bus2.clr_count = 1'b0;
      rst_n          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_x", 32'(bus.x), 32'd0);
      checkOutput("rst_y", 32'(bus.y), 32'd0);
      checkOutput("rst_x_ones", 32'(bus.x_ones), 32'd0);
      checkOutput("rst_txn_count", 32'(bus.txn_count), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Latency: output appears two cycles after the accept
      applyStimulus(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].e);
      @(negedge clk);
      checkOutput("lat_valid_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      checkOutput("lat_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("lat_x", 32'(bus.x), 32'h95);
      @(posedge clk);
      #1;

      // Remaining vectors back-to-back at full throughput
      for (int i = 1; i < 11; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e);
      end
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("drain_table", 32'(sb.size()), 32'd0);
      checkOutput("txn_after_table", 32'(bus.txn_count), 32'(expTxn));

      // Backpressure: two items buffer, third is held off until release
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      applyStimulus(vecs[3].op, vecs[3].a, vecs[3].b, vecs[3].c, vecs[3].e);
      applyStimulus(vecs[4].op, vecs[4].a, vecs[4].b, vecs[4].c, vecs[4].e);
      bus.op       = vecs[0].op;
      bus.a        = vecs[0].a;
      bus.b        = vecs[0].b;
      bus.c        = vecs[0].c;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall_x", 32'(bus.x), 32'h96);
         checkOutput("stall_y", 32'(bus.y), 32'hE8);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      applyStimulus(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].e);
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      checkOutput("drain_stall", 32'(sb.size()), 32'd0);
      @(negedge clk);
      checkOutput("txn_after_stall", 32'(bus.txn_count), 32'(expTxn));

      // Clear of the main counter while idle
      @(posedge clk);
      #1;
      bus.clr_count = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_count = 1'b0;
      expTxn = 0;
      @(negedge clk);
      checkOutput("txn_clear", 32'(bus.txn_count), 32'd0);

      // Saturating 4-bit counter: 17 handshakes, then clear during a handshake
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b1;
      for (int k = 0; k < 80 && hs2 < 17; k++) begin
         @(negedge clk);
         if (bus2.out_valid && bus2.out_ready) hs2++;
         if (hs2 == 14) checkOutput("cnt4_at_13", 32'(bus2.txn_count), 32'd13);
      end
      checkOutput("cnt4_handshakes", 32'(hs2), 32'd17);
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("cnt4_saturate", 32'(bus2.txn_count), 32'd15);
      checkOutput("cnt4_clr_hs_valid", 32'(bus2.out_valid), 32'd1);
      bus2.clr_count = 1'b1;
      @(posedge clk);
      #1;
      bus2.clr_count = 1'b0;
      @(negedge clk);
      checkOutput("cnt4_clear_wins", 32'(bus2.txn_count), 32'd0);

      // Reset with both stages full flushes everything
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      applyStimulus(vecs[5].op, vecs[5].a, vecs[5].b, vecs[5].c, vecs[5].e);
      applyStimulus(vecs[6].op, vecs[6].a, vecs[6].b, vecs[6].c, vecs[6].e);
      @(negedge clk);
      checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      expTxn = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("flush_x", 32'(bus.x), 32'd0);
      checkOutput("flush_txn_count", 32'(bus.txn_count), 32'd0);
      checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("flush_no_output", 32'(bus.out_valid), 32'd0);
      checkOutput("flush_txn_stays", 32'(bus.txn_count), 32'd0);

      // One more item after the flush to show the pipe still works
      @(posedge clk);
      #1;
      applyStimulus(vecs[7].op, vecs[7].a, vecs[7].b, vecs[7].c, vecs[7].e);
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      checkOutput("final_drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
